uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised successor to the fixed-message UART transmitter in the TinyTapeout top level. Accepts data words over a valid/ready handshake into a small FIFO and serialises them onto `tx_pin` with configurable baud, word width, parity and stop bits. It sits between on-chip message sources (ROM sequencer, LCD mirror logic) and `io_out[7]`.

## Interface
- `CLOCK_RATE`, 1000, clock frequency in Hz
- `BAUD_RATE`, 100, bit rate; `CLKS_PER_BIT = CLOCK_RATE/BAUD_RATE` must be an integer ≥ 2 (elaboration error otherwise)
- `DATA_BITS`, 8, word width, legal range 5..9
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even
- `STOP_BITS`, 1, legal values 1 or 2
- `FIFO_DEPTH`, 4, power of two, ≥ 2
- `clk` in 1: single clock, taken from `io_in[0]` at top level
- `reset` in 1: asynchronous, active-high
- `data_in` in DATA_BITS: word to transmit
- `data_valid` in 1: `data_in` is valid
- `data_ready` out 1: FIFO not full; a word is accepted on a rising edge where `data_valid && data_ready`
- `tx_pin` out 1: serial line, idle high, registered
- `busy` out 1: high while the FIFO is non-empty or a frame is in progress
- `fifo_count` out clog2(FIFO_DEPTH+1): number of queued words, excluding the word being shifted

## Operation
- Reset (async): `tx_pin`=1, `busy`=0, `data_ready`=1, `fifo_count`=0, FSM in IDLE, FIFO pointers cleared, bit/baud counters 0.
- Frame: start (0), DATA_BITS data LSB first, optional parity, STOP_BITS stop (1). Frame length = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits.
- Parity is computed over the data bits only. Odd: the total count of ones in data+parity is odd. Even: that count is even.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. The word is popped into the shift register on the same edge.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY or STOP after DATA_BITS bit periods.
  - PARITY → STOP after one bit period.
  - STOP → START (pop on the same edge) if the FIFO is non-empty at the end of the final stop bit. Otherwise STOP → IDLE.
- Every bit holds for exactly CLKS_PER_BIT cycles. The baud counter restarts at each bit boundary. There is no idle gap between back-to-back frames.
- Simultaneous push and pop: both happen, and `fifo_count` is unchanged.
- Full: `data_ready`=0 and `data_valid` is ignored. It returns to 1 on the cycle after a pop.
- Empty FIFO with the FSM in IDLE: `busy`=0.
- Reset mid-frame: the frame is aborted, `tx_pin` goes high immediately, and queued words are discarded.
- `data_in` is sampled only on accept. Its value is don't-care otherwise.

## Timing
- Word accepted at edge k into an empty FIFO with the FSM in IDLE: `fifo_count`=1 after edge k. Pop and `tx_pin` falling edge occur at edge k+1.
- `data_ready` and `fifo_count` are registered and reflect the state after the current edge.
- `busy` rises at edge k. It falls at the edge that ends the last stop bit when no word is queued.
- Frame duration = frame bits × CLKS_PER_BIT cycles, measured from the `tx_pin` falling edge.

## Structure
- Shared package/include `uart_pkg`: PARITY_NONE/ODD/EVEN constants, FSM state encodings, and a CLKS_PER_BIT helper. `lcd` and future serial blocks reuse it.
- Sub-module `uart_fifo`: synchronous FIFO with parameters WIDTH and DEPTH. Ports are push/pop, full/empty and count. Read data comes out of the registered head (first-word fall-through), so a pop delivers the word with no extra cycle.
- The top level replaces the old `uart_tx` instance and ties `data_*` to the message sequencer.

## Test plan
- Defaults; push 0x55 once → `tx_pin` low 1 cycle after accept. Then bits 1,0,1,0,1,0,1,0, each 10 cycles, then stop high. Frame is 100 cycles. `busy` falls at cycle 101.
- PARITY=2; push 0x07 → parity bit 1, 110-cycle frame. With PARITY=1 the same word gives parity bit 0.
- DATA_BITS=5, STOP_BITS=2; push 0x1F → start, five 1s, two stop bits. Next queued word's start bit follows at exactly 80 cycles.
- Hold `data_valid` high with 6 distinct words. Expected: 5 accepted, then `data_ready`=0 with `fifo_count`=4. `data_ready` rises after the first frame ends. All 6 frames come out back-to-back in order, 600 cycles total, with no idle high between them.
- Push 3 words, assert `reset` mid-way through data bit 3 of the first frame → `tx_pin`=1 and `fifo_count`=0 immediately, `busy`=0. After release, push 0xA3 → one clean frame of 0xA3 only.
- Push and pop on the same edge at `fifo_count`=2 → count stays 2. Frame order is preserved.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM states and baud helper.
// Reused by the LCD mirror and later serial blocks.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   function automatic int clks_per_bit(input int clock_rate, input int baud_rate);
      return clock_rate / baud_rate;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with first-word fall-through: the head word is always
// presented on o_rdata, so a pop consumes it with no extra cycle.
module uart_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_rdata,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   // Full/empty are judged on the pre-edge count, so a push into a full
   // FIFO is refused even when a pop happens on the same edge.
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready word input into a small FIFO,
// serialised with configurable baud, width, parity and stop bits.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLOCK_RATE = 1000,
   parameter int BAUD_RATE  = 100,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [DATA_BITS-1:0]            data_in,
   input  logic                            data_valid,
   output logic                            data_ready,
   output logic                            tx_pin,
   output logic                            busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

   localparam int CPB = clks_per_bit(CLOCK_RATE, BAUD_RATE);
   localparam int BCW = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int IW  = $clog2(DATA_BITS);
   localparam int CW  = $clog2(FIFO_DEPTH+1);

   localparam logic [BCW-1:0] BAUD_LAST = BCW'(CPB - 1);
   localparam logic [IW-1:0]  DATA_LAST = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0]  STOP_LAST = IW'(STOP_BITS - 1);

   if ((BAUD_RATE <= 0) || (CLOCK_RATE % BAUD_RATE != 0) || (CPB < 2)) begin : g_bad_baud
      $error("uart_tx_fifo: CLOCK_RATE/BAUD_RATE must be an integer >= 2");
   end
   if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be 5..9");
   end
   if ((PARITY < PARITY_NONE) || (PARITY > PARITY_EVEN)) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
   end
   if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
   end

   tx_state_t            r_state;
   logic [BCW-1:0]       r_baud;
   logic [IW-1:0]        r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par;
   logic                 r_tx;

   logic [DATA_BITS-1:0] w_fifo_rdata;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;
   logic [CW-1:0]        w_fifo_count;
   logic                 w_bit_end;
   logic                 w_last_stop;
   logic                 w_pop;
   logic                 w_par_calc;

   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .i_push  (data_valid),
      .i_wdata (data_in),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   assign w_bit_end   = (r_baud == BAUD_LAST);
   assign w_last_stop = (r_state == ST_STOP) && w_bit_end && (r_bit == STOP_LAST);
   // Pop from IDLE, or at the end of the last stop bit so frames run back-to-back.
   assign w_pop       = !w_fifo_empty && ((r_state == ST_IDLE) || w_last_stop);
   assign w_par_calc  = (PARITY == PARITY_ODD) ? ~(^w_fifo_rdata) : (^w_fifo_rdata);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_tx    <= 1'b1;
      end else begin
         r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
         case (r_state)
            ST_IDLE: begin
               r_baud <= '0;
               r_tx   <= 1'b1;
               if (w_pop) begin
                  r_state <= ST_START;
                  r_shift <= w_fifo_rdata;
                  r_par   <= w_par_calc;
                  r_bit   <= '0;
                  r_tx    <= 1'b0;
               end
            end
            ST_START: begin
               if (w_bit_end) begin
                  r_state <= ST_DATA;
                  r_bit   <= '0;
                  r_tx    <= r_shift[0];
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  if (r_bit == DATA_LAST) begin
                     r_bit <= '0;
                     if (PARITY != PARITY_NONE) begin
                        r_state <= ST_PARITY;
                        r_tx    <= r_par;
                     end else begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                     end
                  end else begin
                     r_bit   <= r_bit + 1'b1;
                     r_shift <= r_shift >> 1;
                     r_tx    <= r_shift[1];
                  end
               end
            end
            ST_PARITY: begin
               if (w_bit_end) begin
                  r_state <= ST_STOP;
                  r_bit   <= '0;
                  r_tx    <= 1'b1;
               end
            end
            ST_STOP: begin
               if (w_bit_end) begin
                  if (r_bit == STOP_LAST) begin
                     if (w_pop) begin
                        r_state <= ST_START;
                        r_shift <= w_fifo_rdata;
                        r_par   <= w_par_calc;
                        r_bit   <= '0;
                        r_tx    <= 1'b0;
                     end else begin
                        r_state <= ST_IDLE;
                        r_bit   <= '0;
                        r_tx    <= 1'b1;
                     end
                  end else begin
                     r_bit <= r_bit + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_baud  <= '0;
               r_bit   <= '0;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   assign tx_pin     = r_tx;
   assign busy       = (r_state != ST_IDLE) || !w_fifo_empty;
   assign data_ready = !w_fifo_full;
   assign fifo_count = w_fifo_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Random-stimulus bench for uart_tx_fifo: three configurations checked every
// cycle against a queue-and-frame-bits model of the line.
module tb_uart_tx_fifo;

   localparam int N = 3;
   localparam int P_CPB [N] = '{10, 4, 3};
   localparam int P_DB  [N] = '{8, 7, 9};
   localparam int P_PAR [N] = '{0, 2, 1};
   localparam int P_SB  [N] = '{1, 2, 1};
   localparam int P_DEP [N] = '{4, 2, 8};

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] vld;
   logic [N-1:0] rdy;
   logic [N-1:0] tx;
   logic [N-1:0] bsy;
   logic [8:0]   din [N];
   logic [2:0]   cnt0;
   logic [1:0]   cnt1;
   logic [3:0]   cnt2;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .CLOCK_RATE (1000), .BAUD_RATE (100), .DATA_BITS (8),
      .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (4)
   ) u0 (
      .clk (clk), .reset (rst), .data_in (din[0][7:0]), .data_valid (vld[0]),
      .data_ready (rdy[0]), .tx_pin (tx[0]), .busy (bsy[0]), .fifo_count (cnt0)
   );

   uart_tx_fifo #(
      .CLOCK_RATE (1000), .BAUD_RATE (250), .DATA_BITS (7),
      .PARITY (2), .STOP_BITS (2), .FIFO_DEPTH (2)
   ) u1 (
      .clk (clk), .reset (rst), .data_in (din[1][6:0]), .data_valid (vld[1]),
      .data_ready (rdy[1]), .tx_pin (tx[1]), .busy (bsy[1]), .fifo_count (cnt1)
   );

   uart_tx_fifo #(
      .CLOCK_RATE (300), .BAUD_RATE (100), .DATA_BITS (9),
      .PARITY (1), .STOP_BITS (1), .FIFO_DEPTH (8)
   ) u2 (
      .clk (clk), .reset (rst), .data_in (din[2]), .data_valid (vld[2]),
      .data_ready (rdy[2]), .tx_pin (tx[2]), .busy (bsy[2]), .fifo_count (cnt2)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model: a queue of accepted words plus the bit pattern of the frame on the line.
   int m_q    [N][16];
   int m_head [N];
   int m_size [N];
   bit m_act  [N];
   int m_t    [N];
   int m_bits [N][16];
   int m_len  [N];

   function automatic void m_reset();
      for (int i = 0; i < N; i++) begin
         m_head[i] = 0;
         m_size[i] = 0;
         m_act[i]  = 1'b0;
         m_t[i]    = 0;
      end
   endfunction

   function automatic void m_load(input int i, input int w);
      int d;
      int ones;
      int k;
      d    = w & ((1 << P_DB[i]) - 1);
      ones = $countones(d);
      k    = 0;
      m_bits[i][k++] = 0;
      for (int b = 0; b < P_DB[i]; b++) m_bits[i][k++] = (d >> b) & 1;
      if (P_PAR[i] == 1) m_bits[i][k++] = (ones % 2 == 0) ? 1 : 0;
      if (P_PAR[i] == 2) m_bits[i][k++] = ones % 2;
      for (int s = 0; s < P_SB[i]; s++) m_bits[i][k++] = 1;
      m_len[i] = k;
   endfunction

   function automatic void m_step(input int i, input bit v, input int w);
      int pre;
      pre = m_size[i];
      if (m_act[i]) begin
         m_t[i]++;
         if (m_t[i] == m_len[i] * P_CPB[i]) m_act[i] = 1'b0;
      end
      if (!m_act[i] && m_size[i] > 0) begin
         m_load(i, m_q[i][m_head[i]]);
         m_head[i] = (m_head[i] + 1) % 16;
         m_size[i]--;
         m_act[i] = 1'b1;
         m_t[i]   = 0;
      end
      if (v && pre < P_DEP[i]) begin
         m_q[i][(m_head[i] + m_size[i]) % 16] = w;
         m_size[i]++;
      end
   endfunction

   function automatic int exp_tx(input int i);
      return m_act[i] ? m_bits[i][m_t[i] / P_CPB[i]] : 1;
   endfunction

   function automatic int dut_cnt(input int i);
      case (i)
         0:       return int'(cnt0);
         1:       return int'(cnt1);
         default: return int'(cnt2);
      endcase
   endfunction

   task automatic check_all();
      for (int i = 0; i < N; i++) begin
         check($sformatf("u%0d.tx_pin", i), int'(tx[i]), exp_tx(i));
         check($sformatf("u%0d.busy", i), int'(bsy[i]), (m_act[i] || m_size[i] > 0) ? 1 : 0);
         check($sformatf("u%0d.data_ready", i), int'(rdy[i]), (m_size[i] < P_DEP[i]) ? 1 : 0);
         check($sformatf("u%0d.fifo_count", i), dut_cnt(i), m_size[i]);
      end
   endtask

   // mode: 0 idle, 1 sparse, 2 medium, 3 always valid, 4 push fixw once
   task automatic cycle(input int mode, input int only, input int fixw);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         bit v;
         case (mode)
            0:       v = 1'b0;
            1:       v = ($urandom_range(0, 29) == 0);
            2:       v = ($urandom_range(0, 3) == 0);
            default: v = 1'b1;
         endcase
         if (only >= 0 && i != only) v = 1'b0;
         vld[i] = v;
         din[i] = (mode == 4) ? 9'(fixw) : 9'($urandom);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) m_step(i, vld[i], int'(din[i]));
      check_all();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit hit;
      vld = '0;
      for (int i = 0; i < N; i++) din[i] = '0;
      m_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b0;

      cycle(4, -1, 'h55);
      repeat (130) cycle(0, -1, 0);
      cycle(4, -1, 'h07);
      repeat (130) cycle(0, -1, 0);
      repeat (600) cycle(1, -1, 0);
      repeat (300) cycle(3, -1, 0);
      repeat (1500) cycle(2, -1, 0);
      repeat (600) cycle(0, -1, 0);

      repeat (3) cycle(3, 0, 0);
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
         if (m_act[0] && m_t[0] == 4 * P_CPB[0] + P_CPB[0] / 2) hit = 1'b1;
         else cycle(0, -1, 0);
      end
      check("reset_window_found", int'(hit), 1);
      #1 rst = 1'b1;
      #1;
      m_reset();
      check_all();
      #1 rst = 1'b0;
      cycle(4, 0, 'hA3);
      repeat (150) cycle(0, -1, 0);

      repeat (800) cycle(2, -1, 0);
      repeat (700) cycle(0, -1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
